// File: rtl/obi_bram_adapter.sv
// OBI subordinate front-end for a single-port byte-write BRAM with 2-entry response skid FIFO.
// Define OBI_BRAM_ERR_EN to reject out-of-range or be==0 accesses with an error response.
module obi_bram_adapter #(
    parameter int NB_COL    = 4,
    parameter int COL_WIDTH = 8,
    parameter int RAM_DEPTH = 1024,
    parameter int AddrWidth = 32
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              obi_req_i,
    output logic                              obi_gnt_o,
    input  logic [AddrWidth-1:0]              obi_addr_i,
    input  logic                              obi_we_i,
    input  logic [NB_COL-1:0]                 obi_be_i,
    input  logic [NB_COL*COL_WIDTH-1:0]       obi_wdata_i,
    output logic                              obi_rvalid_o,
    input  logic                              obi_rready_i,
    output logic [NB_COL*COL_WIDTH-1:0]       obi_rdata_o,
    output logic                              obi_err_o,
    output logic                              mem_req_o,
    output logic [$clog2(RAM_DEPTH)-1:0]      mem_addr_o,
    output logic [NB_COL*COL_WIDTH-1:0]       mem_wdata_o,
    output logic [NB_COL-1:0]                 mem_bwe_o,
    input  logic [NB_COL*COL_WIDTH-1:0]       mem_rdata_i
);

    localparam int DataWidth = NB_COL * COL_WIDTH;
    localparam int ByteOff   = $clog2(NB_COL);
    localparam int WordAw    = $clog2(RAM_DEPTH);

    logic                 pending_q;
    logic                 pend_we_q;
    logic [1:0]           cnt_q;
    logic [1:0]           cnt_d;
    logic                 wr_ptr_q;
    logic                 rd_ptr_q;
    logic [DataWidth-1:0] fifo_rdata_q [2];
    logic [1:0]           outst;
    logic                 hs;
    logic                 acc_err;
    logic                 rsp_err;
    logic                 head_err;
    logic                 push;
    logic                 pop;
    logic                 fifo_nempty;
    logic [DataWidth-1:0] rsp_rdata;
    logic                 unused_addr;

    assign unused_addr = ^obi_addr_i;

    assign outst     = {1'b0, pending_q} + cnt_q;
    assign obi_gnt_o = obi_req_i && (outst < 2'd2) && rst_ni;
    assign hs        = obi_gnt_o;

`ifdef OBI_BRAM_ERR_EN
    logic pend_err_q;
    logic fifo_err_q [2];

    assign acc_err  = (obi_addr_i[AddrWidth-1:ByteOff+WordAw] != '0) ||
                      (obi_be_i == '0);
    assign rsp_err  = pend_err_q;
    assign head_err = fifo_err_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_err_q <= 1'b0;
        end else begin
            pend_err_q <= hs && acc_err;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_err_q[wr_ptr_q] <= rsp_err;
        end
    end
`else
    assign acc_err  = 1'b0;
    assign rsp_err  = 1'b0;
    assign head_err = 1'b0;
`endif

    assign mem_req_o   = hs && !acc_err;
    assign mem_addr_o  = obi_addr_i[ByteOff +: WordAw];
    assign mem_wdata_o = obi_wdata_i;
    assign mem_bwe_o   = (mem_req_o && obi_we_i) ? obi_be_i : '0;

    // Writes and rejected accesses never expose the BRAM read port.
    assign rsp_rdata   = (pend_we_q || rsp_err) ? '0 : mem_rdata_i;

    assign fifo_nempty = (cnt_q != 2'd0);
    assign push        = pending_q && (fifo_nempty || !obi_rready_i);
    assign pop         = fifo_nempty && obi_rready_i;
    assign cnt_d       = cnt_q + {1'b0, push} - {1'b0, pop};

    assign obi_rvalid_o = pending_q || fifo_nempty;

    always_comb begin
        obi_rdata_o = '0;
        obi_err_o   = 1'b0;
        if (fifo_nempty) begin
            obi_rdata_o = fifo_rdata_q[rd_ptr_q];
            obi_err_o   = head_err;
        end else if (pending_q) begin
            obi_rdata_o = rsp_rdata;
            obi_err_o   = rsp_err;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q <= 1'b0;
            pend_we_q <= 1'b0;
            cnt_q     <= 2'd0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
        end else begin
            pending_q <= hs;
            pend_we_q <= hs && obi_we_i;
            cnt_q     <= cnt_d;
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_rdata_q[wr_ptr_q] <= rsp_rdata;
        end
    end

    // The grant rule caps outstanding at 2, so a full FIFO never sees a push.
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push && cnt_q == 2'd2));

endmodule

// File: tb/tb_obi_bram_adapter.sv
// Scoreboard bench for obi_bram_adapter with a behavioural registered-read BRAM.
module tb_obi_bram_adapter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        gnt;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic        err;
    logic        mem_req;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_bwe;
    logic [31:0] mem_rdata;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int hs_cnt    = 0;
    logic [32:0] exp_q [$];

    always #5 clk = ~clk;

    obi_bram_adapter dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .obi_req_i    (req),
        .obi_gnt_o    (gnt),
        .obi_addr_i   (addr),
        .obi_we_i     (we),
        .obi_be_i     (be),
        .obi_wdata_i  (wdata),
        .obi_rvalid_o (rvalid),
        .obi_rready_i (rready),
        .obi_rdata_o  (rdata),
        .obi_err_o    (err),
        .mem_req_o    (mem_req),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_bwe_o    (mem_bwe),
        .mem_rdata_i  (mem_rdata)
    );

    logic [31:0] ram [1024];
    always @(posedge clk) begin
        if (mem_req) begin
            for (int b = 0; b < 4; b++)
                if (mem_bwe[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            mem_rdata <= ram[mem_addr];
        end
    end

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] expv);
        total_cnt++;
        if (act === expv) pass_cnt++;
        else $display("FAIL %s: got %h want %h", nm, act, expv);
    endtask

    // Monitor: pop and compare on each response handshake; check hold under stall.
    logic        held_v = 1'b0;
    logic [32:0] held_d;
    always @(negedge clk) begin
        if (rst_n && rvalid) begin
            if (held_v) check("rsp_stable", {31'd0, err, rdata}, {31'd0, held_d});
            if (rready) begin
                held_v = 1'b0;
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", {31'd0, err, rdata}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    check("rsp_data", {31'd0, err, rdata}, {31'd0, exp_q.pop_front()});
                end
            end else begin
                held_v = 1'b1;
                held_d = {err, rdata};
            end
        end else begin
            held_v = 1'b0;
        end
    end

    task automatic issue(input logic [31:0] a, input logic w, input logic [3:0] b,
                         input logic [31:0] wd, input logic [31:0] er, input logic ee,
                         output logic o_mreq, output logic [9:0] o_maddr,
                         output logic [3:0] o_bwe, output int waited);
        waited = 0;
        req = 1'b1; addr = a; we = w; be = b; wdata = wd;
        @(negedge clk);
        while (!gnt && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!gnt) begin
            check("gnt_timeout", 64'd0, 64'd1);
        end else begin
            o_mreq  = mem_req;
            o_maddr = mem_addr;
            o_bwe   = mem_bwe;
            exp_q.push_back({ee, er});
        end
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || rvalid) && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("drain", {32'd0, exp_q.size()}, 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic       mr;
        logic [9:0] ma;
        logic [3:0] mb;
        int         wt;
        int         h0;

        rst_n = 1'b0; req = 1'b1; addr = 32'h10; we = 1'b1; be = 4'hF;
        wdata = 32'h1234_5678; rready = 1'b1;
        @(negedge clk);
        check("rst_gnt", {63'd0, gnt}, 64'd0);
        check("rst_rvalid", {63'd0, rvalid}, 64'd0);
        check("rst_mem_req", {63'd0, mem_req}, 64'd0);
        check("rst_bwe", {60'd0, mem_bwe}, 64'd0);
        check("rst_rdata", {32'd0, rdata}, 64'd0);
        check("rst_err", {63'd0, err}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; req = 1'b0;

        // Write then read the same word in consecutive cycles
        issue(32'h10, 1'b1, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b0, mr, ma, mb, wt);
        check("wr_mem_req", {63'd0, mr}, 64'd1);
        check("wr_mem_addr", {54'd0, ma}, 64'd4);
        check("wr_bwe", {60'd0, mb}, 64'hF);
        issue(32'h10, 1'b0, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b0, mr, ma, mb, wt);
        check("rd_mem_addr", {54'd0, ma}, 64'd4);
        check("rd_bwe", {60'd0, mb}, 64'd0);
        @(negedge clk);
        check("rd_latency", {63'd0, rvalid}, 64'd1);
        @(posedge clk); #1;

        // Byte-lane write over existing word
        issue(32'h10, 1'b1, 4'b0001, 32'h0000_0055, 32'h0, 1'b0, mr, ma, mb, wt);
        check("lane_bwe", {60'd0, mb}, 64'h1);
        issue(32'h10, 1'b0, 4'hF, 32'h0, 32'hDEAD_BE55, 1'b0, mr, ma, mb, wt);

        for (int i = 0; i < 16; i++)
            issue(i * 4, 1'b1, 4'hF, 32'hC0DE_0000 + i, 32'h0, 1'b0, mr, ma, mb, wt);
        wait_drain();

        // Backpressure: two accepted, then stall until rready returns
        rready = 1'b0;
        issue(32'h0, 1'b0, 4'hF, 32'h0, 32'hC0DE_0000, 1'b0, mr, ma, mb, wt);
        issue(32'h4, 1'b0, 4'hF, 32'h0, 32'hC0DE_0001, 1'b0, mr, ma, mb, wt);
        req = 1'b1; addr = 32'h8; we = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_gnt_low", {63'd0, gnt}, 64'd0);
            check("bp_rvalid", {63'd0, rvalid}, 64'd1);
            @(posedge clk); #1;
        end
        rready = 1'b1;
        issue(32'h8, 1'b0, 4'hF, 32'h0, 32'hC0DE_0002, 1'b0, mr, ma, mb, wt);
        issue(32'hC, 1'b0, 4'hF, 32'h0, 32'hC0DE_0003, 1'b0, mr, ma, mb, wt);
        wait_drain();

        // Streaming: one grant and one response per cycle
        h0 = hs_cnt;
        for (int i = 0; i < 16; i++) begin
            issue(i * 4, 1'b0, 4'hF, 32'h0, 32'hC0DE_0000 + i, 1'b0, mr, ma, mb, wt);
            check("stream_gnt_wait", {32'd0, wt}, 64'd0);
        end
        @(negedge clk); #1;
        check("stream_rsp_count", {32'd0, hs_cnt - h0}, 64'd16);
        @(posedge clk); #1;
        wait_drain();

        // Reset while the FIFO holds two responses
        rready = 1'b0;
        issue(32'h14, 1'b0, 4'hF, 32'h0, 32'hC0DE_0005, 1'b0, mr, ma, mb, wt);
        issue(32'h18, 1'b0, 4'hF, 32'h0, 32'hC0DE_0006, 1'b0, mr, ma, mb, wt);
        @(posedge clk); #1;
        @(negedge clk);
        check("fifo_full_rvalid", {63'd0, rvalid}, 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b0; req = 1'b1; addr = 32'h1C; we = 1'b0;
        #1;
        check("mid_rst_rvalid", {63'd0, rvalid}, 64'd0);
        check("mid_rst_gnt", {63'd0, gnt}, 64'd0);
        check("mid_rst_mem_req", {63'd0, mem_req}, 64'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1; rready = 1'b1;
        issue(32'h1C, 1'b0, 4'hF, 32'h0, 32'hC0DE_0007, 1'b0, mr, ma, mb, wt);
        check("post_rst_gnt_wait", {32'd0, wt}, 64'd0);
        wait_drain();

        // Out-of-range address: error response or alias to word 0
`ifdef OBI_BRAM_ERR_EN
        issue(32'h1000, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1, mr, ma, mb, wt);
        check("oor_mem_req", {63'd0, mr}, 64'd0);
`else
        issue(32'h1000, 1'b0, 4'hF, 32'h0, 32'hC0DE_0000, 1'b0, mr, ma, mb, wt);
        check("oor_mem_req", {63'd0, mr}, 64'd1);
        check("oor_mem_addr", {54'd0, ma}, 64'd0);
`endif
        check("oor_gnt_wait", {32'd0, wt}, 64'd0);
        wait_drain();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/obi_bram_adapter.md
Name: obi_bram_adapter

Overview:
- OBI subordinate front-end that sits directly upstream of the single-port byte-write BRAM in the FPGA memory subsystem.
- Converts OBI requests (req/gnt address phase, rvalid/rready response phase) into BRAM req/addr/wdata/bwe.
- Captures the BRAM's 1-cycle registered read data.
- Buffers responses in a 2-entry skid FIFO so `obi_rready_i` backpressure never loses data.

Parameters:
- NB_COL, 4, bytes per word; must match the BRAM.
- COL_WIDTH, 8, bits per byte lane.
- RAM_DEPTH, 1024, BRAM word count (power of two).
- AddrWidth, 32, OBI byte-address width.
- (localparam) DataWidth = NB_COL*COL_WIDTH.
- (localparam) ByteOff = $clog2(NB_COL).
- (localparam) WordAw = $clog2(RAM_DEPTH).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- obi_req_i  in  1  OBI address-phase request
- obi_gnt_o  out  1  grant
- obi_addr_i  in  AddrWidth  byte address
- obi_we_i  in  1  1=write
- obi_be_i  in  NB_COL  byte enables
- obi_wdata_i  in  DataWidth  write data
- obi_rvalid_o  out  1  response valid
- obi_rready_i  in  1  response ready
- obi_rdata_o  out  DataWidth  read data (0 for writes)
- obi_err_o  out  1  response error
- mem_req_o  out  1  BRAM request
- mem_addr_o  out  WordAw  BRAM word address
- mem_wdata_o  out  DataWidth  BRAM write data
- mem_bwe_o  out  NB_COL  BRAM byte write enables
- mem_rdata_i  in  DataWidth  BRAM read data, valid the cycle after mem_req_o

Behaviour:
- Reset (async, rst_ni=0): pending_q=0, FIFO count=0, pointers=0.
  - Outputs during reset: obi_gnt_o=0, obi_rvalid_o=0, obi_rdata_o=0, obi_err_o=0, mem_req_o=0, mem_bwe_o=0.
  - Reset mid-transaction drops all in-flight and buffered responses.
- Outstanding: outst = pending_q + fifo_cnt, range 0..2.
- Grant: obi_gnt_o = obi_req_i && outst<2 && rst_ni. Combinational; no same-cycle pop credit.
- Handshake fires in cycle N when req&&gnt:
  - mem_req_o=1.
  - mem_addr_o = obi_addr_i[ByteOff +: WordAw].
  - mem_wdata_o = obi_wdata_i.
  - mem_bwe_o = we ? be : 0.
  - mem_req_o, mem_bwe_o = 0 when no handshake.
- Pending register (set at the end of cycle N): pending_q=1, pend_we_q=we, pend_err_q=err (see Optional Feature).
- Cycle N+1:
  - Response word = {rdata: pend_we_q|pend_err_q ? 0 : mem_rdata_i, err: pend_err_q}.
  - Fall-through when FIFO empty: obi_rvalid_o=1 with the response word directly.
  - If rready=1, the response is consumed.
  - If rready=0, the response is pushed into the FIFO.
  - When FIFO non-empty: the FIFO head drives the outputs and the new response is pushed to the tail.
- FIFO: 2 entries, {rdata, err}.
  - Push and pop in the same cycle are allowed.
  - Pointers wrap modulo 2.
  - Push when count=2 is unreachable by the grant rule; guard with an assertion.
- Ordering: responses return strictly in grant order.
- Throughput: 1 transaction/cycle when rready is held high. Latency gnt→rvalid is 1 cycle.
- Response outputs are held stable while rvalid=1 and rready=0.
- Read-after-write to the same word in consecutive cycles returns new data: the BRAM read port samples after the write cycle.
- The write response carries rdata=0, never stale BRAM output.

Optional Feature:
- Macro: OBI_BRAM_ERR_EN.
- Defined:
  - An access is rejected if obi_addr_i[AddrWidth-1:ByteOff+WordAw] != 0 (out of range), or if obi_be_i == 0.
  - A rejected access is still granted, but mem_req_o=0.
  - Its response has err=1, rdata=0, and it occupies a pending/FIFO slot like a normal access.
- Undefined:
  - Upper address bits are ignored (aliasing wrap-around) and be=0 writes are no-ops.
  - obi_err_o is tied 0 and the pend_err_q/FIFO err storage is removed.

Test Plan:
- Write then read: write 0xDEADBEEF to addr 0x10, be=4'hF; read addr 0x10 next cycle, rready=1.
  - mem_addr_o=4 on both; read rvalid at grant+1 with rdata=0xDEADBEEF, err=0.
- Byte lanes: over 0xDEADBEEF, write 0x00000055 with be=4'b0001.
  - Read returns 0xDEADBE55.
- Backpressure: 4 back-to-back reads of 0x0,0x4,0x8,0xC with rready=0 for 3 cycles.
  - gnt drops after 2 accepted; rvalid held with data[0] stable.
  - On rready=1, responses drain in order and remaining grants resume; no loss or duplication.
- Streaming: 16 reads with rready=1 continuously.
  - 16 grants in 16 cycles, rvalid every cycle from grant+1, data in order.
- Reset mid-flight: assert rst_ni=0 while FIFO holds 2 responses.
  - rvalid/gnt/mem_req immediately 0; after release, outst=0 and the first new read returns correct data.
- OBI_BRAM_ERR_EN with RAM_DEPTH=1024: read addr 0x1000.
  - gnt=1, mem_req_o=0, rvalid next cycle with err=1, rdata=0.
  - Without the macro, the same access aliases to word 0 with err=0.
